// File: rtl/decoder_pipe_pkg.sv
// Shared constants for the decode stage.
//   Opcode encodings the decoder treats specially (everything else takes the
//   default short-immediate path), destination write-position encodings and
//   the occupancy state of the output/skid buffer pair.
package decoder_pipe_pkg;

    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'hC;

    localparam logic [1:0] WPOS_FULL = 2'd0;
    localparam logic [1:0] WPOS_LOW  = 2'd1;
    localparam logic [1:0] WPOS_HIGH = 2'd2;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/decoder_pipe_decode_comb.sv
// decode_comb: purely combinational field split, immediate widening and
// legality lookup for one 16-bit instruction.
//   instruction  in   16         raw instruction
//   opcode       out  4          instruction[15:12]
//   rd_select    out  3          instruction[11:9]
//   mode         out  1          instruction[8]
//   ra_select    out  3          instruction[7:5]
//   rb_select    out  3          instruction[4:2]
//   write_pos    out  2          full word / low byte / high byte
//   immediate    out  IMM_WIDTH  sign- or zero-extended immediate
//   illegal      out  1          opcode not enabled in LEGAL_MASK
module decode_comb
    import decoder_pipe_pkg::*;
#(
    parameter int          IMM_WIDTH  = 8,
    parameter logic [15:0] LEGAL_MASK = 16'hFFFF
) (
    input  logic [15:0]          instruction,
    output logic [3:0]           opcode,
    output logic [2:0]           rd_select,
    output logic                 mode,
    output logic [2:0]           ra_select,
    output logic [2:0]           rb_select,
    output logic [1:0]           write_pos,
    output logic [IMM_WIDTH-1:0] immediate,
    output logic                 illegal
);

    logic [4:0] imm5;

    assign opcode    = instruction[15:12];
    assign rd_select = instruction[11:9];
    assign mode      = instruction[8];
    assign ra_select = instruction[7:5];
    assign rb_select = instruction[4:2];
    assign illegal   = ~LEGAL_MASK[opcode];

    // Extensions are built by filling the whole word first and then
    // overwriting the low bits, so IMM_WIDTH == 8 needs no zero-width
    // replication.
    always_comb begin
        imm5      = instruction[4:0];
        write_pos = WPOS_FULL;
        immediate = '0;
        if (opcode == OP_WRITE) begin
            // WRITE reuses the rD field as the top of its immediate
            imm5           = {instruction[11:9], instruction[1:0]};
            immediate      = {IMM_WIDTH{imm5[4]}};
            immediate[4:0] = imm5;
        end else if (opcode == OP_LOAD || opcode == OP_JMP) begin
            immediate[7:0] = instruction[7:0];
            write_pos      = mode ? WPOS_HIGH : WPOS_LOW;
        end else begin
            immediate      = {IMM_WIDTH{imm5[4]}};
            immediate[4:0] = imm5;
        end
    end

endmodule

// File: rtl/decoder_pipe.sv
// decoder_pipe: elastic decode stage between fetch and register read.
//   Decodes on the input side, then holds results in an output register plus
//   one skid slot so the upstream ready is purely registered and the stage
//   still sustains one instruction per cycle.
//   I_clk / I_reset       clock, synchronous active-low reset
//   I_valid / O_ready     upstream handshake, I_instruction + I_pc payload
//   I_flush               drop everything held and anything offered
//   O_valid / I_ready     downstream handshake
//   O_opcode .. O_pc      decoded fields of the instruction at the output
//
//   state     | meaning
//   ----------+-------------------------------------------
//   BUF_EMPTY | nothing held, O_valid = 0
//   BUF_ONE   | output register holds a word
//   BUF_FULL  | output register and skid slot hold words, O_ready = 0
module decoder_pipe
    import decoder_pipe_pkg::*;
#(
    parameter int          IMM_WIDTH  = 8,
    parameter int          PC_WIDTH   = 16,
    parameter logic [15:0] LEGAL_MASK = 16'hFFFF
) (
    input  logic                 I_clk,
    input  logic                 I_reset,
    input  logic                 I_valid,
    output logic                 O_ready,
    input  logic [15:0]          I_instruction,
    input  logic [PC_WIDTH-1:0]  I_pc,
    input  logic                 I_flush,
    output logic                 O_valid,
    input  logic                 I_ready,
    output logic [3:0]           O_opcode,
    output logic [2:0]           O_rD_select,
    output logic [2:0]           O_rA_select,
    output logic [2:0]           O_rB_select,
    output logic                 O_mode,
    output logic [1:0]           O_rD_write_pos,
    output logic [IMM_WIDTH-1:0] O_immediate,
    output logic                 O_illegal,
    output logic [PC_WIDTH-1:0]  O_pc
);

    typedef struct packed {
        logic [3:0]           opcode;
        logic [2:0]           rd_select;
        logic [2:0]           ra_select;
        logic [2:0]           rb_select;
        logic                 mode;
        logic [1:0]           write_pos;
        logic [IMM_WIDTH-1:0] immediate;
        logic                 illegal;
        logic [PC_WIDTH-1:0]  pc;
    } word_t;

    logic [3:0]           dec_opcode;
    logic [2:0]           dec_rd;
    logic [2:0]           dec_ra;
    logic [2:0]           dec_rb;
    logic                 dec_mode;
    logic [1:0]           dec_wpos;
    logic [IMM_WIDTH-1:0] dec_imm;
    logic                 dec_illegal;

    word_t      dec_word;
    word_t      out_word;
    word_t      skid_word;
    buf_state_t state;
    buf_state_t state_next;
    logic       accept;
    logic       drain;
    logic       load_out_in;
    logic       load_out_skid;
    logic       load_skid;

    decode_comb #(
        .IMM_WIDTH  (IMM_WIDTH),
        .LEGAL_MASK (LEGAL_MASK)
    ) u_decode (
        .instruction (I_instruction),
        .opcode      (dec_opcode),
        .rd_select   (dec_rd),
        .mode        (dec_mode),
        .ra_select   (dec_ra),
        .rb_select   (dec_rb),
        .write_pos   (dec_wpos),
        .immediate   (dec_imm),
        .illegal     (dec_illegal)
    );

    assign dec_word = '{
        opcode:    dec_opcode,
        rd_select: dec_rd,
        ra_select: dec_ra,
        rb_select: dec_rb,
        mode:      dec_mode,
        write_pos: dec_wpos,
        immediate: dec_imm,
        illegal:   dec_illegal,
        pc:        I_pc
    };

    // Ready depends only on the state register and reset, never on I_ready.
    assign O_ready = I_reset & (state != BUF_FULL);
    assign O_valid = (state != BUF_EMPTY);
    assign accept  = I_valid & O_ready;
    assign drain   = O_valid & I_ready;

    always_comb begin
        state_next    = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (I_flush) begin
            state_next = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        load_out_in = 1'b1;
                        state_next  = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (drain && accept) begin
                        load_out_in = 1'b1;
                    end else if (drain) begin
                        state_next = BUF_EMPTY;
                    end else if (accept) begin
                        load_skid  = 1'b1;
                        state_next = BUF_FULL;
                    end
                end
                BUF_FULL: begin
                    // accept is impossible here since O_ready is low
                    if (drain) begin
                        load_out_skid = 1'b1;
                        state_next    = BUF_ONE;
                    end
                end
                default: state_next = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_reset) begin
            state     <= BUF_EMPTY;
            out_word  <= '0;
            skid_word <= '0;
        end else begin
            state <= state_next;
            if (load_out_in) begin
                out_word <= dec_word;
            end else if (load_out_skid) begin
                out_word <= skid_word;
            end
            if (load_skid) begin
                skid_word <= dec_word;
            end
        end
    end

    assign O_opcode       = out_word.opcode;
    assign O_rD_select    = out_word.rd_select;
    assign O_rA_select    = out_word.ra_select;
    assign O_rB_select    = out_word.rb_select;
    assign O_mode         = out_word.mode;
    assign O_rD_write_pos = out_word.write_pos;
    assign O_immediate    = out_word.immediate;
    assign O_illegal      = out_word.illegal;
    assign O_pc           = out_word.pc;

endmodule
